// File: rtl/core_mul_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : core_mul_pkg
//  Description : Shared types and constants for the multiplier scheduler:
//                RV64M multiply op encoding, scheduler FSM states and the
//                widths used for word ops and the double-width product.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package core_mul_pkg;

   localparam int unsigned XLEN_DEF = 64;
   localparam int unsigned WORD_W   = 32;
   localparam int unsigned PROD_W   = 2 * XLEN_DEF;

   // Encoding matches the request op field driven by the execute stages.
   typedef enum logic [1:0] {
      MUL    = 2'b00,
      MULH   = 2'b01,
      MULHSU = 2'b10,
      MULHU  = 2'b11
   } mul_op_e;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ISSUE = 3'd1,
      WAIT  = 3'd2,
      ZERO  = 3'd3,
      RESP  = 3'd4
   } sched_state_e;

endpackage : core_mul_pkg
`default_nettype wire

// File: rtl/core_mul_sched_if.sv
`default_nettype none
// ============================================================================
//  Module      : core_mul_sched_if
//  Description : Bundle of the requester handshakes and the multiplier
//                engine connection seen by core_mul_sched. Member names are
//                written from the scheduler's point of view (i_ = into it).
//  Modports    : slave  - the scheduler
//                master - requesters plus the shift-add engine
//  Revision    : 1.0 - initial release
// ============================================================================
interface core_mul_sched_if
   import core_mul_pkg::*;
#(
   parameter int unsigned XLEN    = XLEN_DEF,
   parameter int unsigned NUM_REQ = 2
);

   logic [NUM_REQ-1:0]      i_req_valid;
   logic [NUM_REQ-1:0]      o_req_ready;
   logic [NUM_REQ*2-1:0]    i_req_op;
   logic [NUM_REQ-1:0]      i_req_word;
   logic [NUM_REQ*XLEN-1:0] i_req_rs1;
   logic [NUM_REQ*XLEN-1:0] i_req_rs2;
   logic [NUM_REQ-1:0]      o_rsp_valid;
   logic [NUM_REQ-1:0]      i_rsp_ready;
   logic [XLEN-1:0]         o_rsp_data;
   logic                    o_mul_en;
   logic [XLEN-1:0]         o_mul_multiplicand;
   logic [XLEN-1:0]         o_mul_multiplier;
   logic                    i_mul_done;
   logic [2*XLEN-1:0]       i_mul_product;

   modport slave (
      input  i_req_valid, i_req_op, i_req_word, i_req_rs1, i_req_rs2,
      input  i_rsp_ready, i_mul_done, i_mul_product,
      output o_req_ready, o_rsp_valid, o_rsp_data,
      output o_mul_en, o_mul_multiplicand, o_mul_multiplier
   );

   modport master (
      output i_req_valid, i_req_op, i_req_word, i_req_rs1, i_req_rs2,
      output i_rsp_ready, i_mul_done, i_mul_product,
      input  o_req_ready, o_rsp_valid, o_rsp_data,
      input  o_mul_en, o_mul_multiplicand, o_mul_multiplier
   );

endinterface : core_mul_sched_if
`default_nettype wire

// File: rtl/core_mul_sched_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : core_rr_arbiter
//  Description : Round-robin arbiter. Searches the request vector starting
//                at the pointer and grants the first requester found; the
//                pointer moves past the winner on every grant.
//  Ports       : i_booth_clk/i_booth_rstn - clock, async active-low reset
//                req       - request vector
//                en        - arbitration enable (no grant when low)
//                grant     - one-hot grant
//                grant_idx - index of the granted requester
//  Revision    : 1.0 - initial release
// ============================================================================
module core_rr_arbiter #(
   parameter  int unsigned N  = 2,
   localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic          i_booth_clk,
   input  logic          i_booth_rstn,
   input  logic [N-1:0]  req,
   input  logic          en,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] grant_idx
);

   logic [IW-1:0] ptr;
   logic [IW-1:0] cand;
   logic          found;

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      cand      = '0;
      for (int i = 0; i < int'(N); i++) begin
         cand = IW'((int'(ptr) + i) % int'(N));
         if (en && !found && req[cand]) begin
            grant[cand] = 1'b1;
            grant_idx   = cand;
            found       = 1'b1;
         end
      end
   end

   always_ff @(posedge i_booth_clk or negedge i_booth_rstn) begin
      if (!i_booth_rstn) begin
         ptr <= '0;
      end else if (found) begin
         if (int'(grant_idx) == int'(N) - 1) begin
            ptr <= '0;
         end else begin
            ptr <= grant_idx + IW'(1);
         end
      end
   end

endmodule : core_rr_arbiter
`default_nettype wire

// File: rtl/core_mul_sched.sv
`default_nettype none
// ============================================================================
//  Module      : core_mul_sched
//  Description : Shares one unsigned iterative multiplier among NUM_REQ
//                execute stages and implements MUL/MULH/MULHSU/MULHU/MULW on
//                top of it (sign conditioning, result negation, half/word
//                selection). Zero operands bypass the engine.
//  Ports       : i_booth_clk/i_booth_rstn - clock, async active-low reset
//                bus (slave) - request/response handshakes per requester
//                              and the engine start/operands/done/product
//  Revision    : 1.0 - initial release
// ============================================================================
module core_mul_sched
   import core_mul_pkg::*;
#(
   parameter int unsigned XLEN    = XLEN_DEF,
   parameter int unsigned NUM_REQ = 2
) (
   input  logic            i_booth_clk,
   input  logic            i_booth_rstn,
   core_mul_sched_if.slave bus
);

   localparam int unsigned IW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int unsigned PRODW = 2 * XLEN;

   sched_state_e        state, state_nx;
   logic [IW-1:0]       owner;
   mul_op_e             op_q;
   logic                word_q;
   logic                neg_q;
   logic [XLEN-1:0]     mcand;
   logic [XLEN-1:0]     mplier;
   logic [XLEN-1:0]     result;

   logic                arb_en;
   logic [NUM_REQ-1:0]  grant;
   logic [IW-1:0]       grant_idx;
   logic                req_hs;

   mul_op_e             sel_op;
   logic                sel_word;
   logic [XLEN-1:0]     sel_a, sel_b;
   logic [XLEN-1:0]     eff_a, eff_b;
   logic [XLEN-1:0]     mag_a, mag_b;
   logic                sa, sb;
   logic                zero_opnd;

   logic [PRODW-1:0]    prod_s;
   logic [XLEN-1:0]     res_c;
   logic                mul_en_c;
   logic [NUM_REQ-1:0]  rsp_valid_c;

   // Reset gates the grant so that o_req_ready is low during reset even
   // while requesters keep their valids up.
   assign arb_en = (state == IDLE) && i_booth_rstn;

   core_rr_arbiter #(
      .N (NUM_REQ)
   ) u_arb (
      .i_booth_clk  (i_booth_clk),
      .i_booth_rstn (i_booth_rstn),
      .req          (bus.i_req_valid),
      .en           (arb_en),
      .grant        (grant),
      .grant_idx    (grant_idx)
   );

   assign req_hs = |grant;

   // Fields of the requester currently being granted.
   assign sel_op   = mul_op_e'(bus.i_req_op[int'(grant_idx)*2 +: 2]);
   assign sel_word = bus.i_req_word[grant_idx];
   assign sel_a    = bus.i_req_rs1[int'(grant_idx)*int'(XLEN) +: XLEN];
   assign sel_b    = bus.i_req_rs2[int'(grant_idx)*int'(XLEN) +: XLEN];

   // Word ops use the zero-extended low halves as unsigned operands; the
   // low 32 product bits do not depend on signedness.
   assign eff_a = sel_word ? {{(XLEN-WORD_W){1'b0}}, sel_a[WORD_W-1:0]} : sel_a;
   assign eff_b = sel_word ? {{(XLEN-WORD_W){1'b0}}, sel_b[WORD_W-1:0]} : sel_b;

   assign sa = !sel_word && ((sel_op == MULH) || (sel_op == MULHSU)) && eff_a[XLEN-1];
   assign sb = !sel_word && (sel_op == MULH) && eff_b[XLEN-1];

   // -(-2^63) wraps back to 2^63, which is the correct unsigned magnitude.
   assign mag_a = sa ? -eff_a : eff_a;
   assign mag_b = sb ? -eff_b : eff_b;

   assign zero_opnd = (eff_a == '0) || (eff_b == '0);

   assign prod_s = neg_q ? -bus.i_mul_product : bus.i_mul_product;

   always_comb begin
      res_c = prod_s[XLEN-1:0];
      if (word_q) begin
         res_c = {{(XLEN-WORD_W){prod_s[WORD_W-1]}}, prod_s[WORD_W-1:0]};
      end else if (op_q != MUL) begin
         res_c = prod_s[PRODW-1:XLEN];
      end
   end

   always_comb begin
      state_nx    = state;
      mul_en_c    = 1'b0;
      rsp_valid_c = '0;
      case (state)
         IDLE: begin
            if (req_hs) begin
               state_nx = zero_opnd ? ZERO : ISSUE;
            end
         end
         ISSUE: begin
            mul_en_c = 1'b1;
            state_nx = WAIT;
         end
         WAIT: begin
            if (bus.i_mul_done) begin
               state_nx = RESP;
            end
         end
         ZERO: begin
            state_nx = RESP;
         end
         RESP: begin
            rsp_valid_c[owner] = 1'b1;
            if (bus.i_rsp_ready[owner]) begin
               state_nx = IDLE;
            end
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   always_ff @(posedge i_booth_clk or negedge i_booth_rstn) begin
      if (!i_booth_rstn) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_ff @(posedge i_booth_clk or negedge i_booth_rstn) begin
      if (!i_booth_rstn) begin
         owner  <= '0;
         op_q   <= MUL;
         word_q <= 1'b0;
         neg_q  <= 1'b0;
         mcand  <= '0;
         mplier <= '0;
         result <= '0;
      end else begin
         if ((state == IDLE) && req_hs) begin
            owner  <= grant_idx;
            op_q   <= sel_op;
            word_q <= sel_word;
            neg_q  <= sa ^ sb;
            mcand  <= mag_a;
            mplier <= mag_b;
         end
         if ((state == WAIT) && bus.i_mul_done) begin
            result <= res_c;
         end
         if (state == ZERO) begin
            result <= '0;
         end
      end
   end

   assign bus.o_req_ready        = grant;
   assign bus.o_mul_en           = mul_en_c;
   assign bus.o_mul_multiplicand = mcand;
   assign bus.o_mul_multiplier   = mplier;
   assign bus.o_rsp_valid        = rsp_valid_c;
   assign bus.o_rsp_data         = result;

endmodule : core_mul_sched
`default_nettype wire

// File: tb/tb_core_mul_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_core_mul_sched
//  Description : Self-checking bench for core_mul_sched. Models the 64-cycle
//                unsigned engine, drives directed and random requests and
//                compares results against a signed/unsigned arithmetic model.
//  Ports       : none
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_core_mul_sched;
   import core_mul_pkg::*;

   localparam int XLEN = 64;
   localparam int NREQ = 2;

   logic clk  = 1'b0;
   logic rstn = 1'b1;
   int   cyc  = 0;
   int   n_checks  = 0;
   int   n_fail    = 0;
   int   stab_viol = 0;
   int   rr_ptr    = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   core_mul_sched_if #(.XLEN(XLEN), .NUM_REQ(NREQ)) bus ();

   core_mul_sched #(
      .XLEN    (XLEN),
      .NUM_REQ (NREQ)
   ) dut (
      .i_booth_clk  (clk),
      .i_booth_rstn (rstn),
      .bus          (bus)
   );

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_wait(input string tag, input int to, input int limit);
      n_checks++;
      if (to >= limit) begin
         n_fail++;
         $error("FAIL %s: wait expired after %0d cycles", tag, to);
      end
   endtask

   // Engine model: start on en, done exactly 64 cycles later, product only
   // valid in the done cycle (random garbage otherwise).
   logic        eng_busy;
   int          eng_cnt;
   logic [63:0] eng_a, eng_b;

   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         eng_busy          <= 1'b0;
         eng_cnt           <= 0;
         eng_a             <= '0;
         eng_b             <= '0;
         bus.i_mul_done    <= 1'b0;
         bus.i_mul_product <= '0;
      end else begin
         bus.i_mul_done    <= 1'b0;
         bus.i_mul_product <= {$urandom(), $urandom(), $urandom(), $urandom()};
         if (eng_busy && ((bus.o_mul_multiplicand != eng_a) ||
                          (bus.o_mul_multiplier != eng_b))) begin
            stab_viol++;
         end
         if (bus.o_mul_en) begin
            eng_busy <= 1'b1;
            eng_cnt  <= 1;
            eng_a    <= bus.o_mul_multiplicand;
            eng_b    <= bus.o_mul_multiplier;
         end else if (eng_busy) begin
            eng_cnt <= eng_cnt + 1;
            if (eng_cnt == 63) begin
               eng_busy          <= 1'b0;
               bus.i_mul_done    <= 1'b1;
               bus.i_mul_product <= {64'b0, eng_a} * {64'b0, eng_b};
            end
         end
      end
   end

   // Reference: full-width two's-complement product of sign/zero-extended
   // operands, then pick the requested half or the sign-extended word.
   function automatic logic [63:0] ref_mul(input logic [1:0] op, input logic w,
                                           input logic [63:0] a, input logic [63:0] b);
      logic [127:0] ea, eb, p;
      logic [31:0]  pw;
      if (w) begin
         pw = a[31:0] * b[31:0];
         return {{32{pw[31]}}, pw};
      end
      ea = ((op == 2'b01) || (op == 2'b10)) ? {{64{a[63]}}, a} : {64'b0, a};
      eb = (op == 2'b01) ? {{64{b[63]}}, b} : {64'b0, b};
      p  = ea * eb;
      return (op == 2'b00) ? p[63:0] : p[127:64];
   endfunction

   function automatic logic [NREQ-1:0] oh(input int r);
      logic [NREQ-1:0] v;
      v = '0;
      v[r] = 1'b1;
      return v;
   endfunction

   function automatic logic [63:0] rnd64();
      return {$urandom(), $urandom()};
   endfunction

   logic [1:0]  cur_op [NREQ];
   logic        cur_w  [NREQ];
   logic [63:0] cur_a  [NREQ];
   logic [63:0] cur_b  [NREQ];

   task automatic set_req(input int r, input logic [1:0] op, input logic w,
                          input logic [63:0] a, input logic [63:0] b);
      cur_op[r] = op; cur_w[r] = w; cur_a[r] = a; cur_b[r] = b;
      bus.i_req_op[r*2 +: 2]     = op;
      bus.i_req_word[r]          = w;
      bus.i_req_rs1[r*64 +: 64]  = a;
      bus.i_req_rs2[r*64 +: 64]  = b;
   endtask

   task automatic rand_req(input int r);
      logic [1:0]  op;
      logic        w;
      logic [63:0] a, b;
      op = 2'($urandom_range(0, 3));
      w  = (op == 2'b00) && ($urandom_range(0, 3) == 0);
      a  = rnd64();
      b  = rnd64();
      case ($urandom_range(0, 9))
         0: a = '0;
         1: b = '0;
         2: a = 64'h8000_0000_0000_0000;
         3: b = '1;
         default: ;
      endcase
      set_req(r, op, w, a, b);
   endtask

   // One request from requester r alone, with latency, data and hold checks.
   task automatic run_one(input int r, input logic [1:0] op, input logic w,
                          input logic [63:0] a, input logic [63:0] b,
                          input int hold, input string tag);
      int          k, en_c, rv_c, to;
      bit          zero, ok;
      logic [63:0] exp;
      exp  = ref_mul(op, w, a, b);
      zero = w ? ((a[31:0] == 0) || (b[31:0] == 0)) : ((a == 0) || (b == 0));
      set_req(r, op, w, a, b);
      bus.i_req_valid[r] = 1'b1;
      #1;
      to = 0;
      while (!bus.o_req_ready[r] && to < 300) begin
         @(negedge clk);
         to++;
      end
      chk_wait({tag, " grant wait"}, to, 300);
      chk({tag, " grant"}, bus.o_req_ready, oh(r));
      k = cyc;
      @(posedge clk);
      #1;
      bus.i_req_valid[r] = 1'b0;
      set_req(r, op, w, rnd64(), rnd64());
      en_c = -1;
      rv_c = -1;
      to   = 0;
      while (rv_c < 0 && to < 300) begin
         @(negedge clk);
         if (bus.o_mul_en && en_c < 0) en_c = cyc;
         if (bus.o_rsp_valid != '0) rv_c = cyc;
         to++;
      end
      chk_wait({tag, " rsp wait"}, to, 300);
      chk({tag, " en cycle"}, en_c, zero ? -1 : k + 1);
      chk({tag, " rsp cycle"}, rv_c, zero ? k + 2 : k + 66);
      chk({tag, " rsp owner"}, bus.o_rsp_valid, oh(r));
      chk({tag, " data"}, bus.o_rsp_data, exp);
      if (hold > 0) begin
         ok = 1'b1;
         bus.i_rsp_ready = ~oh(r);
         for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if ((bus.o_rsp_valid !== oh(r)) || (bus.o_rsp_data !== exp)) ok = 1'b0;
         end
         chk({tag, " hold stable"}, ok, 1'b1);
      end
      bus.i_rsp_ready = oh(r);
      @(posedge clk);
      #1;
      bus.i_rsp_ready = '0;
      chk({tag, " rsp released"}, bus.o_rsp_valid, '0);
      rr_ptr = (r + 1) % NREQ;
      @(negedge clk);
   endtask

   initial begin
      int          to, g, n_done, hs_c, last_rsp, exp_owner;
      bit          pending;
      logic [63:0] exp_data;

      bus.i_req_valid = '0;
      bus.i_req_op    = '0;
      bus.i_req_word  = '0;
      bus.i_req_rs1   = '0;
      bus.i_req_rs2   = '0;
      bus.i_rsp_ready = '0;

      // Reset with both requesters asking: every output must stay 0.
      #1 rstn = 1'b0;
      set_req(0, 2'b00, 1'b0, 64'd3, 64'd7);
      set_req(1, 2'b11, 1'b0, 64'd5, 64'd9);
      bus.i_req_valid = '1;
      repeat (3) @(negedge clk);
      #1;
      chk("reset ready", bus.o_req_ready, '0);
      chk("reset rsp_valid", bus.o_rsp_valid, '0);
      chk("reset mul_en", bus.o_mul_en, 1'b0);
      chk("reset mcand", bus.o_mul_multiplicand, '0);
      chk("reset mplier", bus.o_mul_multiplier, '0);
      chk("reset data", bus.o_rsp_data, '0);
      bus.i_req_valid = '0;
      @(negedge clk);
      rstn = 1'b1;
      rr_ptr = 0;
      @(negedge clk);

      run_one(0, 2'b11, 1'b0, '1, '1, 0, "mulhu max");
      run_one(1, 2'b01, 1'b0, 64'h8000_0000_0000_0000, '1, 10, "mulh min");
      run_one(0, 2'b00, 1'b0, 64'h8000_0000_0000_0000, '1, 0, "mul min");
      run_one(1, 2'b10, 1'b0, '1, 64'd2, 0, "mulhsu");
      run_one(0, 2'b00, 1'b1, 64'h0000_0000_7FFF_FFFF, 64'd2, 0, "mulw");
      run_one(1, 2'b00, 1'b0, 64'd0, 64'd5, 0, "mul zero");
      run_one(0, 2'b00, 1'b1, 64'hFFFF_FFFF_0000_0000, 64'd9, 0, "mulw zero low");

      // Reset while the engine is mid-multiply.
      set_req(0, 2'b11, 1'b0, rnd64() | 64'd1, rnd64() | 64'd1);
      bus.i_req_valid[0] = 1'b1;
      #1;
      to = 0;
      while (!bus.o_req_ready[0] && to < 300) begin
         @(negedge clk);
         to++;
      end
      chk_wait("midwait grant wait", to, 300);
      chk("midwait grant", bus.o_req_ready, oh(0));
      @(posedge clk);
      #1;
      repeat (20) @(negedge clk);
      #2;
      rstn = 1'b0;
      #1;
      chk("midwait ready", bus.o_req_ready, '0);
      chk("midwait rsp_valid", bus.o_rsp_valid, '0);
      chk("midwait mul_en", bus.o_mul_en, 1'b0);
      chk("midwait mcand", bus.o_mul_multiplicand, '0);
      chk("midwait mplier", bus.o_mul_multiplier, '0);
      chk("midwait data", bus.o_rsp_data, '0);
      bus.i_req_valid = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rstn   = 1'b1;
      rr_ptr = 0;

      // Both requesters valid continuously: grants alternate, each accepted
      // only in the cycle right after the previous response handshake.
      rand_req(0);
      rand_req(1);
      bus.i_rsp_ready = '1;
      bus.i_req_valid = '1;
      #1;
      pending   = 1'b0;
      n_done    = 0;
      last_rsp  = -1;
      exp_owner = 0;
      exp_data  = '0;
      to        = 0;
      while (n_done < 16 && to < 3000) begin
         if (bus.o_req_ready != '0) begin
            g = 0;
            for (int i = 0; i < NREQ; i++) if (bus.o_req_ready[i]) g = i;
            chk("rr grant", bus.o_req_ready, oh(rr_ptr));
            chk("accept while busy", pending, 1'b0);
            if (last_rsp >= 0) chk("rr throughput", cyc, last_rsp + 1);
            hs_c      = cyc;
            exp_owner = g;
            exp_data  = ref_mul(cur_op[g], cur_w[g], cur_a[g], cur_b[g]);
            pending   = 1'b1;
            rr_ptr    = (g + 1) % NREQ;
            @(posedge clk);
            #1;
            rand_req(g);
         end else if (bus.o_rsp_valid != '0) begin
            chk("rr stale rsp", pending, 1'b1);
            chk("rr rsp owner", bus.o_rsp_valid, oh(exp_owner));
            chk("rr data", bus.o_rsp_data, exp_data);
            pending  = 1'b0;
            last_rsp = cyc;
            n_done++;
            if (n_done == 16) bus.i_req_valid = '0;
         end
         @(negedge clk);
         to++;
      end
      chk_wait("rr wait", to, 3000);
      chk("rr completed", n_done, 16);
      @(posedge clk);
      #1;
      bus.i_rsp_ready = '0;
      @(negedge clk);

      run_one(1, 2'b01, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD, 64'h0000_0000_0000_0007, 3, "mulh neg");

      chk("operand stability", stab_viol, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_core_mul_sched

`default_nettype wire
